sm4_bus_master: RTL and testbench

- Host-side initiator that drives the SM4 core's 32-bit memory-mapped slave register port. One 128-bit job is accepted per handshake.
- Per job it optionally loads a key and triggers key expansion, then writes mode and data, starts the operation, polls for completion and reads back the 128-bit result.
- It sits between a streaming job source and the SM4 slave wrapper, removing all CPU involvement.

---
 rtl/sm4_bus_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_sm4_bus_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_bus_master.sv
`timescale 1ns/1ps
// sm4_bus_master: streaming-job initiator for the SM4 slave register port.
// Each accepted 128-bit job optionally loads and expands a key, writes the
// mode and data words, starts the core, polls for completion and reads the
// four result words back. All bus and handshake outputs are registered.
module sm4_bus_master #(
  parameter int POLL_MAX    = 1024,
  parameter int KEYEXP_WAIT = 4
) (
  input  logic         iClk,
  input  logic         iReset_n,
  input  logic         iJobValid,
  output logic         oJobReady,
  input  logic [127:0] iJobKey,
  input  logic [127:0] iJobData,
  input  logic         iJobDecrypt,
  input  logic         iJobLoadKey,
  output logic         oResValid,
  input  logic         iResReady,
  output logic [127:0] oResData,
  output logic         oResTimeout,
  output logic         oBusy,
  output logic         oChipSelect_n,
  output logic         oWrite_n,
  output logic         oRead_n,
  output logic [4:0]   oAddress,
  output logic [31:0]  oWrData,
  input  logic [31:0]  iRdData
);

  localparam int PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
  localparam int WW = (KEYEXP_WAIT < 2) ? 1 : $clog2(KEYEXP_WAIT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(KEYEXP_WAIT - 1);

  localparam logic [4:0] A_KEXP  = 5'd4;
  localparam logic [4:0] A_DATA0 = 5'd5;
  localparam logic [4:0] A_START = 5'd9;
  localparam logic [4:0] A_MODE  = 5'd10;
  localparam logic [4:0] A_RES0  = 5'd11;
  localparam logic [4:0] A_DONE  = 5'd15;
  localparam logic [4:0] A_KRDY  = 5'd16;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WKEY    = 4'd1,
    S_WKEXP   = 4'd2,
    S_KWAIT   = 4'd3,
    S_KPOLL   = 4'd4,
    S_WMODE   = 4'd5,
    S_WDATA   = 4'd6,
    S_WSTART  = 4'd7,
    S_DPOLL   = 4'd8,
    S_RRES    = 4'd9,
    S_TIMEOUT = 4'd10,
    S_RESP    = 4'd11
  } state_t;

  // Word i of a 128-bit value, word 0 in the most significant position.
  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      2'd3:    w = v[31:0];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  state_t          state_r, state_nxt;
  logic [1:0]      idx_r, idx_nxt;
  logic            phase_r, phase_nxt;   // 0: read strobe cycle, 1: capture cycle
  logic [WW-1:0]   wait_r, wait_nxt;
  logic [PW-1:0]   poll_r, poll_nxt;

  logic [127:0]    key_r, data_r;
  logic            dec_r;
  logic [127:0]    key_src_s, data_src_s;
  logic            dec_src_s;
  logic            accept_s;

  logic            cs_n_nxt, wr_n_nxt, rd_n_nxt;
  logic [4:0]      addr_nxt;
  logic [31:0]     wdata_nxt;
  logic [127:0]    res_data_nxt;
  logic            res_valid_nxt, res_timeout_nxt, job_ready_nxt, busy_nxt;

  logic            cs_n_r, wr_n_r, rd_n_r;
  logic [4:0]      addr_r;
  logic [31:0]     wdata_r;
  logic [127:0]    res_data_r;
  logic            res_valid_r, res_timeout_r, job_ready_r, busy_r;

  assign accept_s = iJobValid && job_ready_r;

  // The first bus cycle of a job is issued straight from the job inputs.
  assign key_src_s  = (state_r == S_IDLE) ? iJobKey     : key_r;
  assign data_src_s = (state_r == S_IDLE) ? iJobData    : data_r;
  assign dec_src_s  = (state_r == S_IDLE) ? iJobDecrypt : dec_r;

  // State and sequencing counters.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_r <= S_IDLE;
      idx_r   <= 2'd0;
      phase_r <= 1'b0;
      wait_r  <= '0;
      poll_r  <= '0;
    end else begin
      state_r <= state_nxt;
      idx_r   <= idx_nxt;
      phase_r <= phase_nxt;
      wait_r  <= wait_nxt;
      poll_r  <= poll_nxt;
    end
  end

  // Next state: walk the job sequence, decide polls on the capture cycle.
  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    phase_nxt = phase_r;
    wait_nxt  = wait_r;
    poll_nxt  = poll_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          idx_nxt   = 2'd0;
          phase_nxt = 1'b0;
          state_nxt = iJobLoadKey ? S_WKEY : S_WMODE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WKEY: begin
        if (idx_r == 2'd3) begin
          idx_nxt   = 2'd0;
          state_nxt = S_WKEXP;
        end else begin
          idx_nxt = idx_r + 2'd1;
        end
      end
      S_WKEXP: begin
        wait_nxt = '0;
        if (KEYEXP_WAIT == 0) begin
          phase_nxt = 1'b0;
          poll_nxt  = '0;
          state_nxt = S_KPOLL;
        end else begin
          state_nxt = S_KWAIT;
        end
      end
      S_KWAIT: begin
        if (wait_r == WAIT_LAST) begin
          phase_nxt = 1'b0;
          poll_nxt  = '0;
          state_nxt = S_KPOLL;
        end else begin
          wait_nxt = wait_r + WW'(1);
        end
      end
      S_KPOLL, S_DPOLL: begin
        if (!phase_r) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (iRdData[0]) begin
            idx_nxt   = 2'd0;
            state_nxt = (state_r == S_KPOLL) ? S_WMODE : S_RRES;
          end else if (poll_r == POLL_LAST) begin
            poll_nxt  = poll_r + PW'(1);
            state_nxt = S_TIMEOUT;
          end else begin
            poll_nxt = poll_r + PW'(1);
          end
        end
      end
      S_WMODE: begin
        idx_nxt   = 2'd0;
        state_nxt = S_WDATA;
      end
      S_WDATA: begin
        if (idx_r == 2'd3) begin
          idx_nxt   = 2'd0;
          state_nxt = S_WSTART;
        end else begin
          idx_nxt = idx_r + 2'd1;
        end
      end
      S_WSTART: begin
        phase_nxt = 1'b0;
        poll_nxt  = '0;
        state_nxt = S_DPOLL;
      end
      S_RRES: begin
        if (!phase_r) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (idx_r == 2'd3) begin
            state_nxt = S_RESP;
          end else begin
            idx_nxt = idx_r + 2'd1;
          end
        end
      end
      S_TIMEOUT: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (iResReady) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RESP;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Next output values: bus cycle belonging to the upcoming state, result slots.
  always_comb begin
    cs_n_nxt        = 1'b1;
    wr_n_nxt        = 1'b1;
    rd_n_nxt        = 1'b1;
    addr_nxt        = 5'd0;
    wdata_nxt       = 32'd0;
    res_data_nxt    = res_data_r;
    res_valid_nxt   = 1'b0;
    res_timeout_nxt = res_timeout_r;
    job_ready_nxt   = (state_nxt == S_IDLE);
    busy_nxt        = (state_nxt != S_IDLE);

    case (state_nxt)
      S_WKEY: begin
        cs_n_nxt = 1'b0; wr_n_nxt = 1'b0;
        addr_nxt  = {3'd0, idx_nxt};
        wdata_nxt = word_of(key_src_s, idx_nxt);
      end
      S_WKEXP: begin
        cs_n_nxt = 1'b0; wr_n_nxt = 1'b0;
        addr_nxt = A_KEXP;
      end
      S_KPOLL: begin
        if (!phase_nxt) begin
          cs_n_nxt = 1'b0; rd_n_nxt = 1'b0;
          addr_nxt = A_KRDY;
        end else begin
          cs_n_nxt = 1'b1;
        end
      end
      S_WMODE: begin
        cs_n_nxt = 1'b0; wr_n_nxt = 1'b0;
        addr_nxt  = A_MODE;
        wdata_nxt = {31'd0, dec_src_s};
      end
      S_WDATA: begin
        cs_n_nxt = 1'b0; wr_n_nxt = 1'b0;
        addr_nxt  = A_DATA0 + {3'd0, idx_nxt};
        wdata_nxt = word_of(data_src_s, idx_nxt);
      end
      S_WSTART: begin
        cs_n_nxt = 1'b0; wr_n_nxt = 1'b0;
        addr_nxt = A_START;
      end
      S_DPOLL: begin
        if (!phase_nxt) begin
          cs_n_nxt = 1'b0; rd_n_nxt = 1'b0;
          addr_nxt = A_DONE;
        end else begin
          cs_n_nxt = 1'b1;
        end
      end
      S_RRES: begin
        if (!phase_nxt) begin
          cs_n_nxt = 1'b0; rd_n_nxt = 1'b0;
          addr_nxt = A_RES0 + {3'd0, idx_nxt};
        end else begin
          cs_n_nxt = 1'b1;
        end
      end
      default: begin
        cs_n_nxt = 1'b1;
      end
    endcase

    if ((state_r == S_RRES) && phase_r) begin
      case (idx_r)
        2'd0:    res_data_nxt[127:96] = iRdData;
        2'd1:    res_data_nxt[95:64]  = iRdData;
        2'd2:    res_data_nxt[63:32]  = iRdData;
        2'd3:    res_data_nxt[31:0]   = iRdData;
        default: res_data_nxt         = res_data_r;
      endcase
    end else begin
      res_data_nxt = res_data_r;
    end

    if (state_nxt == S_TIMEOUT) begin
      res_data_nxt    = 128'd0;
      res_timeout_nxt = 1'b1;
    end else if ((state_r == S_RESP) && (state_nxt == S_IDLE)) begin
      res_timeout_nxt = 1'b0;
    end else begin
      res_timeout_nxt = res_timeout_r;
    end

    if (state_nxt == S_RESP) begin
      res_valid_nxt = 1'b1;
    end else begin
      res_valid_nxt = 1'b0;
    end
  end

  // Latch job fields at acceptance.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      key_r  <= 128'd0;
      data_r <= 128'd0;
      dec_r  <= 1'b0;
    end else if (accept_s) begin
      key_r  <= iJobKey;
      data_r <= iJobData;
      dec_r  <= iJobDecrypt;
    end
  end

  // Register every externally visible output.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      cs_n_r        <= 1'b1;
      wr_n_r        <= 1'b1;
      rd_n_r        <= 1'b1;
      addr_r        <= 5'd0;
      wdata_r       <= 32'd0;
      res_data_r    <= 128'd0;
      res_valid_r   <= 1'b0;
      res_timeout_r <= 1'b0;
      job_ready_r   <= 1'b1;
      busy_r        <= 1'b0;
    end else begin
      cs_n_r        <= cs_n_nxt;
      wr_n_r        <= wr_n_nxt;
      rd_n_r        <= rd_n_nxt;
      addr_r        <= addr_nxt;
      wdata_r       <= wdata_nxt;
      res_data_r    <= res_data_nxt;
      res_valid_r   <= res_valid_nxt;
      res_timeout_r <= res_timeout_nxt;
      job_ready_r   <= job_ready_nxt;
      busy_r        <= busy_nxt;
    end
  end

  assign oChipSelect_n = cs_n_r;
  assign oWrite_n      = wr_n_r;
  assign oRead_n       = rd_n_r;
  assign oAddress      = addr_r;
  assign oWrData       = wdata_r;
  assign oResData      = res_data_r;
  assign oResValid     = res_valid_r;
  assign oResTimeout   = res_timeout_r;
  assign oJobReady     = job_ready_r;
  assign oBusy         = busy_r;

endmodule

// File: tb/tb_sm4_bus_master.sv
`timescale 1ns/1ps
// Bench for sm4_bus_master: a behavioural register-slave model with a toy
// invertible cipher, a bus transaction log, and a job-level reference model.
module tb_sm4_bus_master;

  localparam int POLL_MAX    = 8;
  localparam int KEYEXP_WAIT = 4;
  localparam logic [127:0] MIXC = 128'h5a3c_96e1_0f87_d24b_a5c3_691e_f078_2db4;
  localparam logic [127:0] VEC  = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         job_valid, job_ready, job_dec, job_ld;
  logic [127:0] job_key, job_data;
  logic         res_valid, res_ready, res_timeout, busy;
  logic [127:0] res_data;
  logic         cs_n, wr_n, rd_n;
  logic [4:0]   addr;
  logic [31:0]  wdata, rdata;

  always #5 clk = ~clk;

  sm4_bus_master #(.POLL_MAX(POLL_MAX), .KEYEXP_WAIT(KEYEXP_WAIT)) dut (
    .iClk(clk), .iReset_n(rst_n),
    .iJobValid(job_valid), .oJobReady(job_ready),
    .iJobKey(job_key), .iJobData(job_data),
    .iJobDecrypt(job_dec), .iJobLoadKey(job_ld),
    .oResValid(res_valid), .iResReady(res_ready),
    .oResData(res_data), .oResTimeout(res_timeout), .oBusy(busy),
    .oChipSelect_n(cs_n), .oWrite_n(wr_n), .oRead_n(rd_n),
    .oAddress(addr), .oWrData(wdata), .iRdData(rdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Toy invertible cipher standing in for the SM4 core.
  function automatic logic [127:0] toy_enc(input logic [127:0] d, input logic [127:0] k);
    logic [127:0] t;
    t = d ^ k;
    return {t[119:0], t[127:120]} ^ MIXC;
  endfunction

  function automatic logic [127:0] toy_dec(input logic [127:0] c, input logic [127:0] k);
    logic [127:0] t;
    t = c ^ MIXC;
    return {t[7:0], t[127:8]} ^ k;
  endfunction

  function automatic logic [31:0] wsel(input logic [127:0] v, input int i);
    return v[127 - 32*i -: 32];
  endfunction

  typedef struct packed {
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } bus_t;

  bus_t log_q[$];
  bus_t exp_q[$];
  int   viol = 0;

  // Slave model state.
  logic [31:0] s_key[4], s_data[4], s_res[4];
  logic        s_mode = 1'b0;
  int          k_zero = 0, d_zero = 0, k_reads = 0, d_reads = 0;
  bit          d_stuck = 0;
  bit          rd_pend = 0;
  logic [31:0] rd_val;
  logic [127:0] s_tmp;
  bus_t         ent;

  // Register slave and bus monitor; read data is valid only in the capture cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend = 0;
      rdata   = $urandom;
    end else begin
      if (!wr_n && !rd_n) viol++;
      if (cs_n && (!wr_n || !rd_n || addr != 5'd0 || wdata != 32'd0)) viol++;
      if (!cs_n && wr_n && rd_n) viol++;
      if (!cs_n && !wr_n && rd_n) begin
        ent.wr = 1'b1; ent.a = addr; ent.d = wdata; ent.c = cyc;
        log_q.push_back(ent);
        case (addr)
          5'd0, 5'd1, 5'd2, 5'd3: s_key[int'(addr)] = wdata;
          5'd4: k_reads = 0;
          5'd5, 5'd6, 5'd7, 5'd8: s_data[int'(addr) - 5] = wdata;
          5'd9: begin
            s_tmp = s_mode ? toy_dec({s_data[0], s_data[1], s_data[2], s_data[3]},
                                     {s_key[0], s_key[1], s_key[2], s_key[3]})
                           : toy_enc({s_data[0], s_data[1], s_data[2], s_data[3]},
                                     {s_key[0], s_key[1], s_key[2], s_key[3]});
            for (int i = 0; i < 4; i++) s_res[i] = wsel(s_tmp, i);
            d_reads = 0;
          end
          5'd10: s_mode = wdata[0];
          default: ;
        endcase
        if (rd_pend) begin
          rdata = rd_val;
          rd_pend = 0;
        end else begin
          rdata = $urandom;
        end
      end else if (!cs_n && !rd_n && wr_n) begin
        ent.wr = 1'b0; ent.a = addr; ent.d = 32'd0; ent.c = cyc;
        log_q.push_back(ent);
        case (addr)
          5'd15: begin
            d_reads++;
            rd_val = {31'd0, (!d_stuck && (d_reads > d_zero))};
          end
          5'd16: begin
            k_reads++;
            rd_val = {31'd0, (k_reads > k_zero)};
          end
          5'd11, 5'd12, 5'd13, 5'd14: rd_val = s_res[int'(addr) - 11];
          default: rd_val = 32'd0;
        endcase
        rd_pend = 1;
        rdata   = $urandom;
      end else if (rd_pend) begin
        rdata   = rd_val;
        rd_pend = 0;
      end else begin
        rdata = $urandom;
      end
    end
  end

  logic [127:0] ref_key = 128'd0;

  function automatic int exp_latency(input bit ld, input int kz, input int dz, input bit stuck);
    int l;
    l = 6;
    if (ld) l += 5 + KEYEXP_WAIT + 2 * (kz + 1);
    if (stuck) l += 2 * POLL_MAX + 1;
    else       l += 2 * (dz + 1) + 8;
    return l;
  endfunction

  task automatic push_exp(input logic wr, input int a, input logic [31:0] d);
    bus_t e;
    e.wr = wr; e.a = 5'(a); e.d = d; e.c = 0;
    exp_q.push_back(e);
  endtask

  task automatic build_exp(input logic [127:0] key, input logic [127:0] data,
                           input logic dec, input logic ld, input int kz, input int dz,
                           input bit stuck);
    exp_q.delete();
    if (ld) begin
      for (int i = 0; i < 4; i++) push_exp(1'b1, i, wsel(key, i));
      push_exp(1'b1, 4, 32'd0);
      for (int i = 0; i <= kz; i++) push_exp(1'b0, 16, 32'd0);
    end
    push_exp(1'b1, 10, {31'd0, dec});
    for (int i = 0; i < 4; i++) push_exp(1'b1, 5 + i, wsel(data, i));
    push_exp(1'b1, 9, 32'd0);
    if (stuck) begin
      for (int i = 0; i < POLL_MAX; i++) push_exp(1'b0, 15, 32'd0);
    end else begin
      for (int i = 0; i <= dz; i++) push_exp(1'b0, 15, 32'd0);
      for (int i = 0; i < 4; i++) push_exp(1'b0, 11 + i, 32'd0);
    end
  endtask

  task automatic run_job(input logic [127:0] key, input logic [127:0] data,
                         input logic dec, input logic ld, input int kz, input int dz,
                         input bit stuck, input int hold, input string name);
    logic [127:0] exp_res, held;
    int  acc, n, gap;
    bit  seen, ready_bad, stable_bad;
    if (ld) ref_key = key;
    exp_res = stuck ? 128'd0 : (dec ? toy_dec(data, ref_key) : toy_enc(data, ref_key));
    build_exp(key, data, dec, ld, kz, dz, stuck);
    k_zero = kz; d_zero = dz; d_stuck = stuck;
    @(negedge clk);
    log_q.delete();
    check_val({name, ".job_ready"}, 128'(job_ready), 128'(1));
    job_valid = 1'b1; job_key = key; job_data = data; job_dec = dec; job_ld = ld;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    job_valid = 1'b0;
    job_key  = {$urandom, $urandom, $urandom, $urandom};
    job_data = {$urandom, $urandom, $urandom, $urandom};
    job_dec  = 1'($urandom);
    job_ld   = 1'($urandom);
    check_val({name, ".busy"}, 128'(busy), 128'(1));
    seen = 0; ready_bad = 0;
    for (n = 0; n < 400 && !seen; n++) begin
      if (res_valid) seen = 1;
      else begin
        if (job_ready) ready_bad = 1;
        @(negedge clk);
      end
    end
    check_val({name, ".res_seen"}, 128'(seen), 128'(1));
    check_val({name, ".latency"}, 128'(cyc - acc), 128'(exp_latency(ld, kz, dz, stuck)));
    check_val({name, ".ready_low"}, 128'(ready_bad), 128'(0));
    check_val({name, ".res_data"}, res_data, exp_res);
    check_val({name, ".res_timeout"}, 128'(res_timeout), 128'(stuck));
    held = res_data; stable_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!res_valid || res_data !== held || job_ready || !busy) stable_bad = 1;
    end
    if (hold > 0) check_val({name, ".hold_stable"}, 128'(stable_bad), 128'(0));
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check_val({name, ".after_ack"}, 128'({res_valid, res_timeout, job_ready, busy}), 128'(4'b0010));
    check_val({name, ".log_len"}, 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check_val($sformatf("%s.op[%0d]", name, i), 128'({log_q[i].wr, log_q[i].a}),
                128'({exp_q[i].wr, exp_q[i].a}));
      if (exp_q[i].wr) check_val($sformatf("%s.wd[%0d]", name, i), 128'(log_q[i].d), 128'(exp_q[i].d));
    end
    if (ld && log_q.size() > 5) begin
      gap = log_q[5].c - log_q[4].c;
      check_val({name, ".kexp_gap"}, 128'(gap), 128'(KEYEXP_WAIT + 1));
    end
  endtask

  task automatic reset_mid_job();
    bit found, bad;
    k_zero = 0; d_zero = 0; d_stuck = 0;
    @(negedge clk);
    job_valid = 1'b1; job_ld = 1'b0; job_dec = 1'b0;
    job_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      if (!wr_n && addr == 5'd6) found = 1;
      else @(negedge clk);
    end
    check_val("rst_mid.found_wdata", 128'(found), 128'(1));
    rst_n = 1'b0;
    #1;
    check_val("rst_mid.strobes", 128'({cs_n, wr_n, rd_n}), 128'(3'b111));
    check_val("rst_mid.ctl", 128'({job_ready, res_valid, busy}), 128'(3'b100));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid || !cs_n || !job_ready) bad = 1;
    end
    check_val("rst_mid.quiet", 128'(bad), 128'(0));
  endtask

  initial begin
    int strobes;
    logic [127:0] k, d;
    rst_n = 1'b0; job_valid = 1'b0; job_key = 128'd0; job_data = 128'd0;
    job_dec = 1'b0; job_ld = 1'b0; res_ready = 1'b0; rdata = 32'd0;
    repeat (3) @(negedge clk);
    check_val("rst.ctl", 128'({job_ready, res_valid, res_timeout, busy}), 128'(4'b1000));
    check_val("rst.strobes", 128'({cs_n, wr_n, rd_n}), 128'(3'b111));
    check_val("rst.addr_wd", 128'({addr, wdata}), 128'(0));
    check_val("rst.res_data", res_data, 128'd0);
    rst_n = 1'b1;
    strobes = 0;
    repeat (100) begin
      @(negedge clk);
      if (!cs_n || !wr_n || !rd_n) strobes++;
    end
    check_val("idle.strobes", 128'(strobes), 128'(0));
    check_val("idle.ready", 128'({job_ready, busy}), 128'(2'b10));

    run_job(VEC, VEC, 1'b0, 1'b1, 2, 1, 0, 3, "vec_enc");
    run_job(VEC, toy_enc(VEC, VEC), 1'b1, 1'b0, 0, 2, 0, 0, "vec_dec");
    check_val("vec_dec.roundtrip", res_data, VEC);
    run_job(128'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 0, 0, 0, 20, "lat16");
    run_job(128'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 0, 0, 1, 2, "timeout");
    reset_mid_job();
    run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            1'b0, 1'b1, 0, 0, 0, 1, "post_rst");
    for (int j = 0; j < 8; j++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      run_job(k, d, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              0, $urandom_range(0, 4), $sformatf("rnd%0d", j));
    end
    check_val("bus_protocol", 128'(viol), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
